wishbone_reg_file: RTL and testbench

//  Parametrised Wishbone classic slave register file: next generation of the single-cycle regs block.

---
 rtl/wishbone_reg_file.sv | 93 +++++++++
 tb/tb_wishbone_reg_file.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/wishbone_reg_file.sv
// wishbone_reg_file: Wishbone classic register file with byte lanes, wait states, range/RO errors; WB_REG_FILE_CLEAR_EN adds a post-reset clear sweep
module wishbone_reg_file #(
  parameter int ADDRESS_WIDTH = 14,
  parameter int DATA_WIDTH    = 16,
  parameter int DEPTH         = 1 << ADDRESS_WIDTH,
  parameter int WAIT_STATES   = 0,
  parameter int RO_WORDS      = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDRESS_WIDTH-1:0]  wbAdrI,
  input  logic [DATA_WIDTH-1:0]     wbDatI,
  input  logic [DATA_WIDTH/8-1:0]   wbSelI,
  input  logic                      wbCycI,
  input  logic                      wbStbI,
  input  logic                      wbWeI,
  output logic [DATA_WIDTH-1:0]     wbDatO,
  output logic                      wbAckO,
  output logic                      wbErrO,
  output logic                      busy
);
  localparam int LANES = DATA_WIDTH / 8;
  localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, TERM = 2'd2;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [1:0] state;
  logic [3:0] waitCnt;
  logic [IDX_W-1:0] idx;
  logic req, complete, accErr, doWrite;
  assign req = wbCycI && wbStbI;
  assign idx = wbAdrI[IDX_W-1:0];
  assign complete = rst && state == WAIT && req && waitCnt == '0;
  assign accErr = int'(wbAdrI) >= DEPTH || (wbWeI && int'(wbAdrI) < RO_WORDS);
  assign doWrite = complete && wbWeI && !accErr;
`ifdef WB_REG_FILE_CLEAR_EN
  localparam logic [1:0] CLEAR = 2'd3;
  logic clearPend;
  logic [IDX_W-1:0] clearAddr;
  assign busy = state == CLEAR;
`else
  assign busy = 1'b0;
`endif
  always_ff @(posedge clk)
`ifdef WB_REG_FILE_CLEAR_EN
    if (rst && state == CLEAR) mem[clearAddr] <= '0;
    else
`endif
    if (doWrite)
      for (int i = 0; i < LANES; i++)
        if (wbSelI[i]) mem[idx][8*i +: 8] <= wbDatI[8*i +: 8];
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      waitCnt <= '0;
      wbDatO <= '0;
      wbAckO <= 1'b0;
      wbErrO <= 1'b0;
`ifdef WB_REG_FILE_CLEAR_EN
      clearPend <= 1'b1;
      clearAddr <= '0;
`endif
    end else begin
      wbAckO <= complete && !accErr;
      wbErrO <= complete && accErr;
      if (complete && !accErr && !wbWeI) wbDatO <= mem[idx];
      case (state)
        IDLE:
`ifdef WB_REG_FILE_CLEAR_EN
          if (clearPend) begin
            state <= CLEAR;
            clearPend <= 1'b0;
            clearAddr <= '0;
          end else
`endif
          if (req) begin
            state <= WAIT;
            waitCnt <= 4'(WAIT_STATES);
          end
        WAIT: begin
          state <= !req ? IDLE : waitCnt == '0 ? TERM : WAIT;
          if (waitCnt != '0) waitCnt <= waitCnt - 4'd1;
        end
        TERM: state <= IDLE;
`ifdef WB_REG_FILE_CLEAR_EN
        CLEAR: begin
          clearAddr <= clearAddr + 1'b1;
          if (clearAddr == IDX_W'(DEPTH - 1)) state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_wishbone_reg_file.sv
// tb_wishbone_reg_file: randomized Wishbone traffic checked every cycle against a timing/memory reference model
module tb_wishbone_reg_file;
  localparam int AW = 7, DW = 16, DEPTH = 100, WS = 3, RO = 4;
  logic clk = 0, rst = 0;
  logic [AW-1:0] wbAdrI = '0;
  logic [DW-1:0] wbDatI = '0;
  logic [1:0] wbSelI = '0;
  logic wbCycI = 0, wbStbI = 0, wbWeI = 0;
  logic [DW-1:0] wbDatO;
  logic wbAckO, wbErrO, busy;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  wishbone_reg_file #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(WS), .RO_WORDS(RO)) dut (
    .clk(clk), .rst(rst), .wbAdrI(wbAdrI), .wbDatI(wbDatI), .wbSelI(wbSelI), .wbCycI(wbCycI),
    .wbStbI(wbStbI), .wbWeI(wbWeI), .wbDatO(wbDatO), .wbAckO(wbAckO), .wbErrO(wbErrO), .busy(busy));
  logic [DW-1:0] mMem [128];
  logic [1:0] mKnown [128];
  logic [DW-1:0] expDat = '0, expMask = '1;
  logic expAck = 0, expErr = 0, expBusy = 0, checking = 0;
  int cyc = 0, accAt = 0, nextFree = 0, adr = 0;
  bit inAcc = 0;
`ifdef WB_REG_FILE_CLEAR_EN
  bit clrPend = 0;
  int clrLeft = 0;
`endif
  initial for (int i = 0; i < 128; i++) begin mMem[i] = '0; mKnown[i] = '0; end
  always @(posedge clk) begin
    cyc++;
    expAck = 0;
    expErr = 0;
    if (!rst) begin
      inAcc = 0; nextFree = cyc + 1; expDat = '0; expMask = '1; expBusy = 0;
`ifdef WB_REG_FILE_CLEAR_EN
      clrPend = 1; clrLeft = 0;
    end else if (clrPend) begin
      clrPend = 0; clrLeft = DEPTH; expBusy = 1;
    end else if (clrLeft > 0) begin
      clrLeft--;
      if (clrLeft == 0) begin
        expBusy = 0; nextFree = cyc + 1;
        for (int i = 0; i < DEPTH; i++) begin mMem[i] = '0; mKnown[i] = 2'b11; end
      end
`endif
    end else if (inAcc) begin
      if (!(wbCycI && wbStbI)) begin
        inAcc = 0; nextFree = cyc + 1;
      end else if (cyc == accAt + WS + 1) begin
        inAcc = 0; nextFree = cyc + 2; adr = int'(wbAdrI);
        if (adr >= DEPTH || (wbWeI && adr < RO)) expErr = 1;
        else begin
          expAck = 1;
          if (wbWeI) begin
            for (int l = 0; l < 2; l++)
              if (wbSelI[l]) begin mMem[adr][8*l +: 8] = wbDatI[8*l +: 8]; mKnown[adr][l] = 1; end
          end else begin
            expDat = mMem[adr];
            expMask = {{8{mKnown[adr][1]}}, {8{mKnown[adr][0]}}};
          end
        end
      end
    end else if (cyc >= nextFree && wbCycI && wbStbI) begin
      inAcc = 1; accAt = cyc;
    end
  end
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (checking) begin
      chk("ack", DW'(wbAckO), DW'(expAck));
      chk("err", DW'(wbErrO), DW'(expErr));
      chk("busy", DW'(busy), DW'(expBusy));
      chk("rdata", wbDatO & expMask, expDat & expMask);
    end
  task automatic access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] sel,
                        output logic ack, output logic err, output int lat);
    int w = 0;
    @(negedge clk);
    while (busy && w < 300) begin @(negedge clk); w++; end
    wbCycI = 1; wbStbI = 1; wbWeI = we; wbAdrI = a; wbDatI = d; wbSelI = sel;
    ack = 0; err = 0; lat = 0;
    while (!ack && !err && lat < 300) begin
      @(negedge clk);
      lat++;
      ack = wbAckO;
      err = wbErrO;
    end
    wbCycI = 0; wbStbI = 0;
    if (!ack && !err) begin
      checks++; errors++;
      $display("FAIL access_timeout: got no termination expected ack or err");
    end
  endtask
  task automatic randAttr();
    wbWeI = 1'($urandom_range(0, 1));
    wbAdrI = $urandom_range(0, 7) == 0 ? AW'($urandom_range(DEPTH, 127)) : AW'($urandom_range(0, 31));
    wbDatI = DW'($urandom);
    wbSelI = 2'($urandom);
  endtask
  initial begin
    logic a, e, sawTerm;
    int lat;
    repeat (3) @(negedge clk);
    checking = 1;
    chk("reset_dat", wbDatO, 16'h0000);
    chk("reset_ack", DW'(wbAckO), 16'h0000);
    chk("reset_err", DW'(wbErrO), 16'h0000);
    rst = 1;
    access(1, 7'd5, 16'h1234, 2'b11, a, e, lat);
    chk("t1_wr_ack", DW'(a), 16'h0001);
    chk("t1_wr_latency", DW'(lat - 1), 16'd4);
    access(0, 7'd5, 16'h0000, 2'b11, a, e, lat);
    chk("t1_rd_ack", DW'(a), 16'h0001);
    chk("t1_rd_data", wbDatO, 16'h1234);
    access(1, 7'd20, 16'hAAAA, 2'b11, a, e, lat);
    access(1, 7'd20, 16'h55FF, 2'b01, a, e, lat);
    access(0, 7'd20, 16'h0000, 2'b11, a, e, lat);
    chk("t2_lanes", wbDatO, 16'hAAFF);
    @(negedge clk);
    wbCycI = 1; wbStbI = 1; wbWeI = 0; wbAdrI = 7'd5;
    repeat (2) @(negedge clk);
    wbStbI = 0;
    sawTerm = 0;
    repeat (8) begin @(negedge clk); sawTerm |= wbAckO | wbErrO; end
    wbCycI = 0;
    chk("t3_abort_noterm", DW'(sawTerm), 16'h0000);
    access(0, 7'd5, 16'h0000, 2'b11, a, e, lat);
    chk("t3_after_abort_ack", DW'(a), 16'h0001);
    chk("t3_after_abort_latency", DW'(lat - 1), 16'd4);
    access(0, 7'd100, 16'h0000, 2'b11, a, e, lat);
    chk("t4_range_err", DW'({a, e}), 16'h0001);
    access(1, 7'd2, 16'hDEAD, 2'b11, a, e, lat);
    chk("t4_ro_err", DW'({a, e}), 16'h0001);
    access(1, 7'd4, 16'h4444, 2'b11, a, e, lat);
    chk("t4_rw_ack", DW'({a, e}), 16'h0002);
    access(0, 7'd4, 16'h0000, 2'b11, a, e, lat);
    chk("t4_rw_data", wbDatO, 16'h4444);
    access(1, 7'd7, 16'h1111, 2'b11, a, e, lat);
    @(negedge clk);
    wbCycI = 1; wbStbI = 1; wbWeI = 1; wbAdrI = 7'd7; wbDatI = 16'hBEEF; wbSelI = 2'b11;
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    rst = 1; wbCycI = 0; wbStbI = 0;
    chk("t5_reset_outputs", {wbDatO[13:0], wbAckO, wbErrO}, 16'h0000);
    access(0, 7'd7, 16'h0000, 2'b11, a, e, lat);
    chk("t5_first_ack", DW'(a), 16'h0001);
`ifdef WB_REG_FILE_CLEAR_EN
    chk("t5_cleared_data", wbDatO, 16'h0000);
`else
    chk("t5_uncommitted", wbDatO, 16'h1111);
`endif
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (wbCycI && wbStbI) begin
        if ((wbAckO || wbErrO) ? $urandom_range(0, 3) != 0 : $urandom_range(0, 15) == 0) begin
          wbStbI = 0;
          wbCycI = 1'($urandom_range(0, 1));
        end else if ($urandom_range(0, 11) == 0) randAttr();
      end else if ($urandom_range(0, 2) == 0) begin
        randAttr();
        wbCycI = 1;
        wbStbI = 1;
      end
    end
    wbCycI = 0; wbStbI = 0;
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
